// File: rtl/d_operand_stage_pkg.sv
// rtl/d_operand_stage_pkg.sv - shared constants and types for the ID/EX operand stage
//
// Purpose : default widths, the hardwired-zero register number and the
//           forwarding-source enumeration used by the operand stage and its
//           per-source forwarding mux.
// Contents: DATA_W, REG_AW, CTRL_W, REG_ZERO, fwd_sel_e.

package d_operand_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // Where a resolved operand comes from, in decreasing forwarding priority
  // after the register bank fallback.
  typedef enum logic [1:0] {
    FWD_BANK = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_WB   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/d_operand_fwd_mux.sv
// rtl/d_operand_fwd_mux.sv - combinational bypass select for one source operand
//
// Purpose : resolve one source operand from the youngest matching in-flight
//           writer (EX, then MEM, then WB) or from the register bank.
//           Register 0 always resolves to zero.
// Ports   : addr        source register number
//           bank_data   register bank read data for addr
//           ex_en/addr/data   EX bypass (ex_en already excludes loads)
//           mem_en/addr/data  MEM bypass
//           wb_en/addr/data   WB bypass (same-cycle bank write)
//           data        resolved operand

module d_operand_fwd_mux #(
  parameter int DATA_W = d_operand_stage_pkg::DATA_W,
  parameter int REG_AW = d_operand_stage_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] bank_data,
  input  logic              ex_en,
  input  logic [REG_AW-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_en,
  input  logic [REG_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data
);

  import d_operand_stage_pkg::*;

  fwd_sel_e sel;
  logic     is_zero;

  assign is_zero = (addr == '0);

  always_comb begin
    sel = FWD_BANK;
    if (ex_en && (ex_addr == addr)) begin
      sel = FWD_EX;
    end else if (mem_en && (mem_addr == addr)) begin
      sel = FWD_MEM;
    end else if (wb_en && (wb_addr == addr)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    data = bank_data;
    if (is_zero) begin
      // r0 ignores every bypass, even a writer that targets r0.
      data = '0;
    end else begin
      case (sel)
        FWD_EX:  data = ex_data;
        FWD_MEM: data = mem_data;
        FWD_WB:  data = wb_data;
        default: data = bank_data;
      endcase
    end
  end

endmodule

// File: rtl/d_operand_stage.sv
// rtl/d_operand_stage.sv - ID/EX operand stage: bypass, load-use stall, EX register
//
// Purpose : resolves Rs/Rt operands (EX > MEM > WB bypass, then bank), detects
//           load-use hazards, and registers operands/immediate/control into EX
//           under a valid/ready handshake with stall and flush.
// Ports   : i_clk, i_rst_n (async, active-low)
//           i_valid, i_addr_Rs/Rt/Rd, i_data_Rs/Rt, i_imm, i_ctrl  decode side
//           i_ex_*   instruction in EX (valid, RegWr, MemRd, addr, result)
//           i_mem_*  MEM writer;  i_wb_*  WB writer (bank write port)
//           i_ex_ready  EX accepts this cycle;  i_flush  kill decode + stage
//           o_stall  hold PC and IF/ID this cycle
//           o_valid, o_data_Rs/Rt, o_imm, o_ctrl, o_addr_Rs/Rt/Rd  EX-stage
// Options : define D_OPERAND_STAGE_PERF_EN to add saturating 32-bit counters
//           o_perf_stall_cnt (cycles with o_stall) and o_perf_bubble_cnt
//           (load-use bubbles inserted).

module d_operand_stage #(
  parameter int DATA_W = d_operand_stage_pkg::DATA_W,
  parameter int REG_AW = d_operand_stage_pkg::REG_AW,
  parameter int CTRL_W = d_operand_stage_pkg::CTRL_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [REG_AW-1:0] i_addr_Rs,
  input  logic [REG_AW-1:0] i_addr_Rt,
  input  logic [REG_AW-1:0] i_addr_Rd,
  input  logic [DATA_W-1:0] i_data_Rs,
  input  logic [DATA_W-1:0] i_data_Rt,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_ex_valid,
  input  logic              i_ex_RegWr,
  input  logic              i_ex_MemRd,
  input  logic [REG_AW-1:0] i_ex_addr_Rd,
  input  logic [DATA_W-1:0] i_ex_data_Rd,
  input  logic              i_mem_RegWr,
  input  logic [REG_AW-1:0] i_mem_addr_Rd,
  input  logic [DATA_W-1:0] i_mem_data_Rd,
  input  logic              i_wb_RegWr,
  input  logic [REG_AW-1:0] i_wb_addr_Rd,
  input  logic [DATA_W-1:0] i_wb_data_Rd,
  input  logic              i_ex_ready,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data_Rs,
  output logic [DATA_W-1:0] o_data_Rt,
  output logic [DATA_W-1:0] o_imm,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [REG_AW-1:0] o_addr_Rs,
  output logic [REG_AW-1:0] o_addr_Rt,
  output logic [REG_AW-1:0] o_addr_Rd
`ifdef D_OPERAND_STAGE_PERF_EN
  ,
  output logic [31:0]       o_perf_stall_cnt,
  output logic [31:0]       o_perf_bubble_cnt
`endif
);

  import d_operand_stage_pkg::*;

  logic              ex_fwd_en;
  logic              load_in_ex;
  logic              hazard;
  logic              backpressure;
  logic [DATA_W-1:0] rs_resolved;
  logic [DATA_W-1:0] rt_resolved;

  // A load in EX has no data yet, so it may not feed the EX bypass; its
  // consumers stall once and then pick the data up from MEM.
  assign ex_fwd_en  = i_ex_valid & i_ex_RegWr & ~i_ex_MemRd;
  assign load_in_ex = i_ex_valid & i_ex_RegWr & i_ex_MemRd & (i_ex_addr_Rd != '0);

  assign hazard       = i_valid & load_in_ex &
                        ((i_ex_addr_Rd == i_addr_Rs) | (i_ex_addr_Rd == i_addr_Rt));
  assign backpressure = o_valid & ~i_ex_ready;

  // Gated by reset so that upstream sees no stall while the stage is held.
  assign o_stall = i_rst_n & (hazard | backpressure) & ~i_flush;

  d_operand_fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs (
    .addr      (i_addr_Rs),
    .bank_data (i_data_Rs),
    .ex_en     (ex_fwd_en),
    .ex_addr   (i_ex_addr_Rd),
    .ex_data   (i_ex_data_Rd),
    .mem_en    (i_mem_RegWr),
    .mem_addr  (i_mem_addr_Rd),
    .mem_data  (i_mem_data_Rd),
    .wb_en     (i_wb_RegWr),
    .wb_addr   (i_wb_addr_Rd),
    .wb_data   (i_wb_data_Rd),
    .data      (rs_resolved)
  );

  d_operand_fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rt (
    .addr      (i_addr_Rt),
    .bank_data (i_data_Rt),
    .ex_en     (ex_fwd_en),
    .ex_addr   (i_ex_addr_Rd),
    .ex_data   (i_ex_data_Rd),
    .mem_en    (i_mem_RegWr),
    .mem_addr  (i_mem_addr_Rd),
    .mem_data  (i_mem_data_Rd),
    .wb_en     (i_wb_RegWr),
    .wb_addr   (i_wb_addr_Rd),
    .wb_data   (i_wb_data_Rd),
    .data      (rt_resolved)
  );

  // Flush beats backpressure beats hazard beats capture. Only o_valid moves
  // on flush or bubble; the payload registers keep their last contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_data_Rs <= '0;
      o_data_Rt <= '0;
      o_imm     <= '0;
      o_ctrl    <= '0;
      o_addr_Rs <= '0;
      o_addr_Rt <= '0;
      o_addr_Rd <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (backpressure) begin
      // EX has not taken the current instruction: hold everything.
    end else if (hazard) begin
      o_valid <= 1'b0;
    end else begin
      o_valid   <= i_valid;
      o_data_Rs <= rs_resolved;
      o_data_Rt <= rt_resolved;
      o_imm     <= i_imm;
      o_ctrl    <= i_ctrl;
      o_addr_Rs <= i_addr_Rs;
      o_addr_Rt <= i_addr_Rt;
      o_addr_Rd <= i_addr_Rd;
    end
  end

`ifdef D_OPERAND_STAGE_PERF_EN
  logic bubble_inserted;

  assign bubble_inserted = ~i_flush & ~backpressure & hazard;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_stall_cnt  <= '0;
      o_perf_bubble_cnt <= '0;
    end else begin
      if (o_stall && (o_perf_stall_cnt != 32'hFFFF_FFFF)) begin
        o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
      end
      if (bubble_inserted && (o_perf_bubble_cnt != 32'hFFFF_FFFF)) begin
        o_perf_bubble_cnt <= o_perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
